// File: rtl/hs_arith_pkg.sv
// Shared definitions for the hs_arith streaming arithmetic blocks.
//   - frame_acc_width(): exact bit width needed to hold len*n words of dw bits
//                        that are all at their maximum value.
//   - uadder_out_width(): same, for a single n-word beat.
//   - hs_frame_acc_state_t: frame accumulator FSM states.
package hs_arith_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } hs_frame_acc_state_t;

  // Returns $clog2(n*len*(2**dw-1)+1) without overflowing for wide words.
  // For dw >= 32 the term 2**dw dominates n*len (at most 2**23). In that case
  // the exact answer is always dw + $clog2(n*len).
  function automatic int frame_acc_width(input int dw, input int n, input int len);
    longint span;
    longint maxv;
    int     w;
    span = longint'(n) * longint'(len);
    if (dw < 32) begin
      maxv = span * ((longint'(1) << dw) - 1);
      w = 0;
      while ((longint'(1) << w) < (maxv + 1)) w = w + 1;
      return w;
    end
    return dw + $clog2(span);
  endfunction

  function automatic int uadder_out_width(input int dw, input int n);
    return frame_acc_width(dw, n, 1);
  endfunction

endpackage

// File: rtl/hs_arith_multi_in_uadder.sv
// Combinational unsigned adder of INPUT_NUM words.
// Ports:
//   din  - INPUT_NUM unsigned words of DATA_WIDTH bits
//   dout - SUM_WIDTH-bit sum, wide enough that it never wraps
module hs_arith_multi_in_uadder
  import hs_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int INPUT_NUM  = 16,
  localparam int SUM_WIDTH = uadder_out_width(DATA_WIDTH, INPUT_NUM)
) (
  input  logic [DATA_WIDTH-1:0] din [INPUT_NUM],
  output logic [SUM_WIDTH-1:0]  dout
);

  // SUM_WIDTH > DATA_WIDTH always holds because INPUT_NUM >= 2.
  always_comb begin
    dout = '0;
    for (int i = 0; i < INPUT_NUM; i++) begin
      dout = dout + {{(SUM_WIDTH-DATA_WIDTH){1'b0}}, din[i]};
    end
  end

endmodule

// File: rtl/hs_arith_frame_uaccumulator.sv
// Streaming frame accumulator.
// Each accepted beat of INPUT_NUM unsigned words is reduced to one sum. That sum
// is added into a running frame total. A frame closes on s_last or after
// FRAME_LEN beats. The total and beat count are then presented on m_*.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_valid/s_ready   - input beat handshake; s_din words, s_last early close
//   m_valid/m_ready   - frame result handshake; m_sum total, m_beats count
//   frame_active      - an open frame has at least one beat accumulated
module hs_arith_frame_uaccumulator
  import hs_arith_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int INPUT_NUM  = 16,
  parameter int FRAME_LEN  = 8,
  localparam int SUM_WIDTH = uadder_out_width(DATA_WIDTH, INPUT_NUM),
  localparam int ACC_WIDTH = frame_acc_width(DATA_WIDTH, INPUT_NUM, FRAME_LEN),
  localparam int CNT_WIDTH = $clog2(FRAME_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_din [INPUT_NUM],
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ACC_WIDTH-1:0]  m_sum,
  output logic [CNT_WIDTH-1:0]  m_beats,
  output logic                  frame_active
);

  hs_frame_acc_state_t    state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]   cnt;

  logic [SUM_WIDTH-1:0]   beat_sum;
  logic [ACC_WIDTH-1:0]   beat_ext;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic                   accept;
  logic                   close;

  // ---- stage 0: combinational beat reduction and close decision ----
  hs_arith_multi_in_uadder #(
    .DATA_WIDTH (DATA_WIDTH),
    .INPUT_NUM  (INPUT_NUM)
  ) u_uadder (
    .din  (s_din),
    .dout (beat_sum)
  );

  // The output register is one deep: a held, unconsumed result is the only
  // source of backpressure. A consumed result may be replaced on the same edge.
  assign s_ready  = !(m_valid && !m_ready);
  assign accept   = s_valid && s_ready;
  assign close    = accept && (s_last || (cnt == CNT_WIDTH'(FRAME_LEN - 1)));

  assign beat_ext = ACC_WIDTH'(beat_sum);
  assign acc_sum  = acc + beat_ext;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);

  assign frame_active = (state == ST_ACC);

  // ---- stage 1: frame state, accumulator and result register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_beats <= '0;
    end else begin
      // A new close below overrides this release, giving back-to-back results.
      if (m_valid && m_ready) m_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (close) begin
            m_valid <= 1'b1;
            m_sum   <= beat_ext;
            m_beats <= CNT_WIDTH'(1);
            acc     <= '0;
            cnt     <= '0;
          end else if (accept) begin
            state <= ST_ACC;
            acc   <= beat_ext;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        ST_ACC: begin
          if (close) begin
            m_valid <= 1'b1;
            m_sum   <= acc_sum;
            m_beats <= cnt_inc;
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
          end else if (accept) begin
            acc <= acc_sum;
            cnt <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_arith_frame_uaccumulator.sv
module tb_hs_arith_frame_uaccumulator;

  localparam int DW = 1;
  localparam int N  = 16;
  localparam int FL = 4;
  localparam int AW = 7;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_din [N];
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_sum;
  logic [CW-1:0] m_beats;
  logic          frame_active;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hs_arith_frame_uaccumulator #(
    .DATA_WIDTH (DW),
    .INPUT_NUM  (N),
    .FRAME_LEN  (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_din        (s_din),
    .s_last       (s_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_sum        (m_sum),
    .m_beats      (m_beats),
    .frame_active (frame_active)
  );

  typedef struct {
    int n;
    int o0;
    int o1;
    int o2;
    int o3;
    bit last;
    int exp_sum;
    int exp_beats;
  } vec_t;

  vec_t tbl [5];

  // Reference model state for the random phase: beats of the open frame, and
  // results produced but not yet consumed downstream.
  int       open_beats [$];
  int       pend_sum [$];
  int       pend_cnt [$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a beat whose first k words are one and the rest zero.
  task automatic set_beat(input int k, input bit v, input bit l);
    for (int j = 0; j < N; j++) s_din[j] = (j < k) ? 1'b1 : 1'b0;
    s_valid = v;
    s_last  = l;
  endtask

  function automatic int tbl_ones(input vec_t v, input int i);
    case (i)
      0: return v.o0;
      1: return v.o1;
      2: return v.o2;
      default: return v.o3;
    endcase
  endfunction

  initial begin
    rst     = 1'b1;
    m_ready = 1'b1;
    set_beat(0, 1'b0, 1'b0);

    tbl[0] = '{4, 16, 3, 0, 16, 1'b0, 35, 4};
    tbl[1] = '{2, 5, 7, 0, 0, 1'b1, 12, 2};
    tbl[2] = '{1, 16, 0, 0, 0, 1'b1, 16, 1};
    tbl[3] = '{4, 16, 16, 16, 16, 1'b0, 64, 4};
    tbl[4] = '{3, 1, 2, 3, 0, 1'b1, 6, 3};

    // ---- reset and idle ----
    step();
    step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_sum", m_sum, 0);
    chk("rst_m_beats", m_beats, 0);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_frame_active", frame_active, 0);
    rst = 1'b0;
    step();
    chk("idle_s_ready", s_ready, 1);
    chk("idle_m_valid", m_valid, 0);

    // ---- reset mid-frame discards the partial sum ----
    set_beat(9, 1'b1, 1'b0);
    step();
    step();
    chk("midrst_active_before", frame_active, 1);
    set_beat(0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_active_after", frame_active, 0);
    chk("midrst_m_valid", m_valid, 0);
    set_beat(3, 1'b1, 1'b1);
    step();
    set_beat(0, 1'b0, 1'b0);
    chk("midrst_next_valid", m_valid, 1);
    chk("midrst_next_sum", m_sum, 3);
    chk("midrst_next_beats", m_beats, 1);
    step();

    // ---- table-driven frames, m_ready held high ----
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        set_beat(tbl_ones(tbl[t], i), 1'b1, (i == tbl[t].n - 1) && tbl[t].last);
        step();
        if (i < tbl[t].n - 1) chk($sformatf("tbl%0d_open_active", t), frame_active, 1);
      end
      set_beat(0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_m_valid", t), m_valid, 1);
      chk($sformatf("tbl%0d_m_sum", t), m_sum, tbl[t].exp_sum);
      chk($sformatf("tbl%0d_m_beats", t), m_beats, tbl[t].exp_beats);
      chk($sformatf("tbl%0d_active", t), frame_active, 0);
      step();
      chk($sformatf("tbl%0d_release", t), m_valid, 0);
    end

    // ---- stalled output: result held, input blocked ----
    m_ready = 1'b0;
    set_beat(10, 1'b1, 1'b0);
    step();
    set_beat(10, 1'b1, 1'b1);
    step();
    set_beat(7, 1'b1, 1'b1);
    #1;
    chk("stall_m_valid", m_valid, 1);
    chk("stall_m_sum", m_sum, 20);
    for (int c = 0; c < 5; c++) begin
      chk("stall_s_ready", s_ready, 0);
      step();
      chk("stall_hold_sum", m_sum, 20);
      chk("stall_hold_beats", m_beats, 2);
      chk("stall_hold_valid", m_valid, 1);
      chk("stall_no_accept", frame_active, 0);
    end
    m_ready = 1'b1;
    #1;
    chk("unstall_s_ready", s_ready, 1);
    step();
    set_beat(0, 1'b0, 1'b0);
    chk("swap_m_valid", m_valid, 1);
    chk("swap_m_sum", m_sum, 7);
    chk("swap_m_beats", m_beats, 1);
    step();
    chk("swap_release", m_valid, 0);

    // ---- back-to-back single-beat frames ----
    for (int k = 1; k <= 3; k++) begin
      set_beat(k, 1'b1, 1'b1);
      step();
      chk("b2b_m_valid", m_valid, 1);
      chk("b2b_m_sum", m_sum, k);
      chk("b2b_m_beats", m_beats, 1);
    end
    set_beat(0, 1'b0, 1'b0);
    step();
    chk("b2b_release", m_valid, 0);

    // ---- full-length all-ones frame with gaps ----
    for (int i = 0; i < FL; i++) begin
      set_beat(16, 1'b1, 1'b0);
      step();
      set_beat(5, 1'b0, 1'b1);  // s_din/s_last must be ignored while !s_valid
      if (i < FL - 1) begin
        step();
        chk("gap_active", frame_active, 1);
        chk("gap_no_result", m_valid, 0);
      end
    end
    chk("gap_m_valid", m_valid, 1);
    chk("gap_m_sum", m_sum, 64);
    chk("gap_m_beats", m_beats, 4);
    chk("gap_active_end", frame_active, 0);
    step();

    // ---- randomized traffic against the frame model ----
    rst = 1'b1;
    set_beat(0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    open_beats.delete();
    pend_sum.delete();
    pend_cnt.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit exp_ready;
      bit hs;
      int ones;
      s_valid = ($urandom_range(0, 9) < 7);
      s_last  = ($urandom_range(0, 9) < 2);
      m_ready = ($urandom_range(0, 9) < 6);
      for (int j = 0; j < N; j++) s_din[j] = DW'($urandom_range(0, 1));
      #1;
      exp_ready = !(pend_sum.size() != 0 && !m_ready);
      chk("rnd_s_ready", s_ready, exp_ready);
      chk("rnd_m_valid", m_valid, pend_sum.size() != 0);
      chk("rnd_frame_active", frame_active, open_beats.size() != 0);
      hs = m_valid && m_ready;
      if (hs && pend_sum.size() != 0) begin
        chk("rnd_m_sum", m_sum, pend_sum[0]);
        chk("rnd_m_beats", m_beats, pend_cnt[0]);
      end
      if (pend_sum.size() != 0 && m_ready) begin
        void'(pend_sum.pop_front());
        void'(pend_cnt.pop_front());
      end
      if (s_valid && exp_ready) begin
        ones = 0;
        for (int j = 0; j < N; j++) ones += int'(s_din[j]);
        open_beats.push_back(ones);
        if (s_last || open_beats.size() == FL) begin
          int tot;
          tot = 0;
          foreach (open_beats[b]) tot += open_beats[b];
          pend_sum.push_back(tot);
          pend_cnt.push_back(open_beats.size());
          open_beats.delete();
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
